// File: rtl/compunit_ne.sv
// rtl/compunit_ne.sv - serial check-node row compressor producing {Min1, Min2, Pos, UpdatedSign}; optional offset min-sum via COMPUNIT_OFFSET_EN
module compunit_ne #(
    parameter int Wc        = 18,
    parameter int Wcbits    = 5,
    parameter int W         = 6,
    parameter int Wabs      = W - 1,
    parameter int ECOMPSIZE = 2 * (W - 1) + Wcbits + Wc
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ECOMPSIZE-1:0] Ecomp
);

    localparam logic [Wcbits-1:0] LAST    = Wcbits'(Wc - 1);
    localparam logic [Wabs-1:0]   MAG_MAX = {Wabs{1'b1}};

    logic [Wcbits-1:0]    cnt_q, cnt_d;
    logic [Wabs-1:0]      min1_q, min1_d;
    logic [Wabs-1:0]      min2_q, min2_d;
    logic [Wcbits-1:0]    pos_q, pos_d;
    logic [Wc-1:0]        raw_q, raw_d;
    logic                 parity_q, parity_d;
    logic [ECOMPSIZE-1:0] ecomp_q, ecomp_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 last_msg;
    logic                 sign;
    logic [W-1:0]         neg;
    logic [Wabs-1:0]      mag;
    logic [Wabs-1:0]      min1_out;
    logic [Wabs-1:0]      min2_out;

`ifdef COMPUNIT_OFFSET_EN
    // Offset min-sum: subtract one from a magnitude, never going below zero
    function automatic logic [Wabs-1:0] offset_mag(input logic [Wabs-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction
`endif

    // Saturated magnitude and sign of the incoming message; -2^(W-1) clips to MAG_MAX
    always_comb begin
        sign = in_msg[W-1];
        neg  = -in_msg;
        mag  = in_msg[Wabs-1:0];
        if (sign) begin
            mag = neg[W-1] ? MAG_MAX : neg[Wabs-1:0];
        end
    end

    assign last_msg  = (cnt_q == LAST);
    assign in_ready  = !(last_msg && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign Ecomp     = ecomp_q;

    // Row accumulation: running minima, position of min1, raw signs and parity
    always_comb begin
        cnt_d    = cnt_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        pos_d    = pos_q;
        raw_d    = raw_q;
        parity_d = parity_q;
        if (accept) begin
            raw_d[cnt_q] = sign;
            cnt_d        = last_msg ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                min1_d   = mag;
                min2_d   = MAG_MAX;
                pos_d    = '0;
                parity_d = sign;
            end else begin
                parity_d = parity_q ^ sign;
                // Strict compares keep the earliest index on ties
                if (mag < min1_q) begin
                    min2_d = min1_q;
                    min1_d = mag;
                    pos_d  = cnt_q;
                end else if (mag < min2_q) begin
                    min2_d = mag;
                end
            end
        end
    end

    // Output register: loads the finished row, otherwise drains on handshake
    always_comb begin
`ifdef COMPUNIT_OFFSET_EN
        min1_out = offset_mag(min1_d);
        min2_out = offset_mag(min2_d);
`else
        min1_out = min1_d;
        min2_out = min2_d;
`endif
        ecomp_d     = ecomp_q;
        out_valid_d = out_valid_q;
        if (accept && last_msg) begin
            ecomp_d     = {min1_out, min2_out, pos_d, raw_d ^ {Wc{parity_d}}};
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            min1_q      <= '0;
            min2_q      <= '0;
            pos_q       <= '0;
            raw_q       <= '0;
            parity_q    <= 1'b0;
            ecomp_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            pos_q       <= pos_d;
            raw_q       <= raw_d;
            parity_q    <= parity_d;
            ecomp_q     <= ecomp_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/compunit_ne.md
# compunit_ne

Serial check-node compression unit: accepts the Wc signed W-bit messages of one row, one per cycle, and produces the compressed row word {Min1, Min2, Pos, UpdatedSign}. This is the encode side of the row-compression scheme whose decode side expands the same word back into Wc messages. It sits between the check-node message source and compressed-row storage.

## Interface
- Wc, 18, messages per row
- Wcbits, 5, width of Pos; requires Wc <= 2^Wcbits
- W, 6, message width (two's complement)
- Wabs, W-1, magnitude width
- ECOMPSIZE, 2*(W-1)+Wcbits+Wc, compressed word width

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_msg is valid
- in_ready  output  1  unit accepts in_msg this cycle
- in_msg  input  W  signed message; row index is implicit (arrival order 0..Wc-1)
- out_valid  output  1  Ecomp holds a completed row
- out_ready  input  1  consumer takes Ecomp this cycle
- Ecomp  output  ECOMPSIZE  {Min1[Wabs], Min2[Wabs], Pos[Wcbits], UpdatedSign[Wc]}, Min1 at the MSBs

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Magnitude: |in_msg|, saturated to 2^Wabs-1; the most negative value (e.g. -32) gives 31. Sign = in_msg[W-1].
- Accumulators: cnt (0..Wc-1), min1, min2, pos, raw sign vector, parity.
- Accepted message at index 0: min1=m, min2=2^Wabs-1, pos=0, parity=sign.
- Index i>0: if m < min1 then min2=min1, min1=m, pos=i; else if m < min2 then min2=m. Comparisons are strict, so on ties the earliest index keeps Pos. parity ^= sign.
- raw sign bit i = sign of message i.
- On acceptance at cnt==Wc-1: load the output register with min1, min2, pos (final values that include this message) and UpdatedSign = raw ^ {Wc{parity}} (final parity). Set out_valid=1 and set cnt=0. UpdatedSign bit i=1 means the message sent back on edge i is negative.
- Otherwise cnt increments on each accepted message.
- The accumulators and the output register are separate, so the unit accumulates the next row while the previous row is held on Ecomp.
- in_ready = !(cnt==Wc-1 && out_valid && !out_ready). The unit stalls only when completing a row would overwrite an undrained output.
- out_valid clears on output transfer unless a new row completes in the same cycle. In that case it stays 1 and Ecomp takes the new row.

## Timing
- Reset (async, rst=0): cnt, accumulators, Ecomp and out_valid are 0; in_ready is 1 during and after reset.
- Reset mid-row discards the partial row and any pending output. The first accepted message after reset is index 0.
- Latency: out_valid and the new Ecomp appear the cycle after the Wc-th message is accepted.
- Throughput: one message per cycle, one row per Wc cycles, with no bubbles while out_ready=1.
- Ecomp is stable while out_valid=1 && out_ready=0.
- Gaps (in_valid=0) pause accumulation without changing state.

## Configuration
- COMPUNIT_OFFSET_EN: if defined, enables offset min-sum.
  - Min1 and Min2 in Ecomp are each reduced by 1, saturating at 0.
  - The offset is applied when the output register loads.
  - Pos and sign logic are unchanged.
- If undefined, Ecomp carries the raw minima.

## Test plan
- Wc=18, W=6; all messages +3 except index 7 = -1 -> Ecomp = {5'd1, 5'd3, 5'd7, 18'h3FF7F}, out_valid one cycle after the 18th accept.
- All messages +5 except indices 2 and 9 = +2 -> Min1=2, Min2=2, Pos=2; UpdatedSign=0.
- All 18 messages = -32 -> Min1=31, Min2=31, Pos=0, UpdatedSign=18'h3FFFF (even parity).
  - Setup: two back-to-back rows with out_ready held 0.
  - in_ready must drop while the 18th message of row 2 is offered.
  - Row 1 Ecomp must stay stable.
  - After a single out_ready pulse, row 2 is accepted and appears next cycle; both rows are bit-exact and no message is lost.
- Assert rst after 5 messages -> out_valid=0, Ecomp=0, in_ready=1. The next 18 messages form a correct complete row.
- With COMPUNIT_OFFSET_EN, rerun the first scenario -> Ecomp = {5'd0, 5'd2, 5'd7, 18'h3FF7F}.
